gpio_in_conditioner: RTL and testbench
======================================

# gpio_in_conditioner

- Input-side front end for the GPIO block.
- Synchronizes raw pad inputs and debounces each pin. Presents a clean, glitch-free bus that drives the GPIO input port (`gpio_in`).
- Detects edges on the clean bus and latches enabled edges into a sticky interrupt status register.
- Status and enables are reached over the same `wr_en`/`rd_en`/`addr`/`wdata`/`rdata` register bus used by the GPIO block.

## Interface
- `WIDTH`, 32: number of pins, 1..32.
- `PRESCALE`, 1000: clock cycles per debounce sample tick, ≥2.
- `STABLE_CNT`, 4: consecutive differing ticks required to accept a new level, ≥1.
- `clk`  in  1  system clock, rising edge.
- `rst`  in  1  asynchronous, active-high reset.
- `pad_in`  in  WIDTH  raw, asynchronous pad levels.
- `wr_en`  in  1  register write strobe, one cycle.
- `rd_en`  in  1  register read strobe, one cycle.
- `addr`  in  8  byte address.
- `wdata`  in  32  write data.
- `rdata`  out  32  read data, registered.
- `gpio_in_clean`  out  WIDTH  debounced levels, connects to GPIO `gpio_in`.
- `irq`  out  1  OR of all STATUS bits.

## Operation
- Register map; bits at WIDTH and above read 0:
  - 0x00 CLEAN: read-only, `gpio_in_clean`.
  - 0x04 RISE_EN: read/write.
  - 0x08 FALL_EN: read/write.
  - 0x0C STATUS: read, write-1-to-clear.
  - 0x10 RAW: read-only, synchronizer output.
  - Other addresses: read 0, writes ignored. Writes to CLEAN and RAW are ignored.
- Synchronizer: 2-flop chain per pin, resets to 0.
- Prescaler:
  - Counts 0..PRESCALE-1 and wraps.
  - `tick` is a 1-cycle pulse while the count equals PRESCALE-1.
- Per-pin debounce counter, evaluated on `tick` only:
  - sync == clean: counter cleared.
  - Otherwise counter increments.
  - When the counter reaches STABLE_CNT: clean <= sync and counter cleared.
  - Counter width is clog2(STABLE_CNT+1). It never wraps.
- Edge detection, in the same cycle clean updates:
  - rise = new 1 & old 0.
  - fall = new 0 & old 1.
- STATUS[i] <= STATUS[i] | (rise[i] & RISE_EN[i]) | (fall[i] & FALL_EN[i]).
- W1C: on a write to 0x0C, bits with wdata=1 clear. If a new event and a clear hit the same bit in the same cycle, set wins.
- Enabling RISE_EN/FALL_EN does not retroactively set STATUS.
- `irq` = |STATUS. Combinational from flops, glitch-free.
- Read: when `rd_en` is high, `rdata` <= selected register on the next edge. Otherwise `rdata` holds.
- Simultaneous `wr_en` and `rd_en` to the same address returns the pre-write value.

## Timing
- Reset values: `rdata`=0, `gpio_in_clean`=0, `irq`=0. Sync flops, prescaler, counters, RISE_EN, FALL_EN and STATUS are all 0.
- Reset mid-debounce discards the partial count. After release, a pad held at 1 is re-qualified from scratch.
- First `tick` occurs PRESCALE cycles after reset deasserts.
- Pad to RAW: 2 cycles.
- Pad to CLEAN: between 2+(STABLE_CNT-1)*PRESCALE+1 and 2+STABLE_CNT*PRESCALE+1 cycles.
- Rejected pulses:
  - Any pulse shorter than (STABLE_CNT-1)*PRESCALE cycles is always rejected.
  - A single tick back at the old level restarts qualification.
- CLEAN to STATUS/`irq`: same edge as the CLEAN update. `irq` is high 0 cycles after STATUS sets.
- Read latency: 1 cycle after `rd_en`.
- Write effect: visible on the next edge.

## Configuration
- Macro: `GPIO_IN_DEBOUNCE_EN`.
- Defined: prescaler and debounce logic as above.
- Undefined:
  - Prescaler and counters are removed. `gpio_in_clean` = sync output, i.e. pad to CLEAN is 2 cycles.
  - Edges are detected on the sync output.
  - `PRESCALE` and `STABLE_CNT` are ignored.
  - Register map unchanged.

## Test plan
Bench uses PRESCALE=4, STABLE_CNT=3, `GPIO_IN_DEBOUNCE_EN` defined unless stated otherwise.
- Reset: `rst`=1, pad=0xA5A5A5A5 -> `rdata`, `gpio_in_clean` and `irq` stay 0. After release, reading 0x10 returns 0xA5A5A5A5. CLEAN reaches 0xA5A5A5A5 within 2+12+1 cycles.
- Glitch rejection: pad[0] pulses high for 6 cycles -> CLEAN[0]=0, STATUS=0, `irq`=0.
- Rise interrupt: write 0x04=0x1, then hold pad[0]=1 -> CLEAN[0]=1 between 11 and 15 cycles. STATUS=0x1 and `irq`=1 on the same edge. Write 0x0C=0x1 -> STATUS=0, `irq`=0 next cycle.
- Disabled fall: FALL_EN=0, drop pad[0] to 0 -> CLEAN[0]=0, STATUS stays 0.
- Set beats clear: write 0x0C=0x1 in the exact cycle a new enabled rise qualifies on pin 0 -> STATUS[0]=1.
- Bus corners and bypass:
  - Read 0x14 -> 0.
  - Write 0x00=0xFFFFFFFF -> CLEAN unchanged.
  - With the macro undefined, a pad step appears on CLEAN after exactly 2 cycles.

Source files
------------

// File: rtl/gpio_in_conditioner.sv
// GPIO input front end: 2-flop sync, per-pin debounce (only with GPIO_IN_DEBOUNCE_EN), sticky edge IRQ status.
// Latency: pad->RAW 2 cycles, register read 1 cycle; no backpressure, bus strobes are always accepted.
module gpio_in_conditioner #(
  parameter int WIDTH      = 32,
  parameter int PRESCALE   = 1000,
  parameter int STABLE_CNT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] pad_in,
  input  logic             wr_en,
  input  logic             rd_en,
  input  logic [7:0]       addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  output logic [WIDTH-1:0] gpio_in_clean,
  output logic             irq
);

  if (WIDTH < 1 || WIDTH > 32 || PRESCALE < 2 || STABLE_CNT < 1) begin : g_bad_cfg
    $error("gpio_in_conditioner: parameter out of range");
  end

  logic [WIDTH-1:0] sync1, sync2, clean, clean_nxt;
  logic [WIDTH-1:0] rise_en, fall_en, status;
  logic [WIDTH-1:0] rise, fall, ev, clr;
  logic [31:0]      rd_mux;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
      clean <= '0;
    end else begin
      sync1 <= pad_in;
      sync2 <= sync1;
      clean <= clean_nxt;
    end
  end

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam int PW = $clog2(PRESCALE);
  localparam int CW = $clog2(STABLE_CNT + 1);

  logic [PW-1:0]            pre_cnt;
  logic                     tick;
  logic [WIDTH-1:0][CW-1:0] db_cnt, db_cnt_nxt;

  assign tick = (pre_cnt == PW'(PRESCALE - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pre_cnt <= '0;
      db_cnt  <= '0;
    end else begin
      pre_cnt <= tick ? '0 : pre_cnt + 1'b1;
      db_cnt  <= db_cnt_nxt;
    end
  end

  // A tick back at the old level clears the count, so qualification restarts.
  always_comb begin
    clean_nxt  = clean;
    db_cnt_nxt = db_cnt;
    if (tick) begin
      for (int i = 0; i < WIDTH; i++) begin
        if (sync2[i] == clean[i]) begin
          db_cnt_nxt[i] = '0;
        end else if (db_cnt[i] == CW'(STABLE_CNT - 1)) begin
          clean_nxt[i]  = sync2[i];
          db_cnt_nxt[i] = '0;
        end else begin
          db_cnt_nxt[i] = db_cnt[i] + 1'b1;
        end
      end
    end
  end
`else
  assign clean_nxt = sync1;
`endif

  // Edges are taken against the value clean is about to load, so STATUS sets on the same edge.
  assign rise = clean_nxt & ~clean;
  assign fall = ~clean_nxt & clean;
  assign ev   = (rise & rise_en) | (fall & fall_en);
  assign clr  = (wr_en && addr == 8'h0C) ? wdata[WIDTH-1:0] : '0;

  always_comb begin
    rd_mux = '0;
    case (addr)
      8'h00:   rd_mux[WIDTH-1:0] = clean;
      8'h04:   rd_mux[WIDTH-1:0] = rise_en;
      8'h08:   rd_mux[WIDTH-1:0] = fall_en;
      8'h0C:   rd_mux[WIDTH-1:0] = status;
      8'h10:   rd_mux[WIDTH-1:0] = sync2;
      default: rd_mux = '0;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rise_en <= '0;
      fall_en <= '0;
      status  <= '0;
      rdata   <= '0;
    end else begin
      if (wr_en && addr == 8'h04) rise_en <= wdata[WIDTH-1:0];
      if (wr_en && addr == 8'h08) fall_en <= wdata[WIDTH-1:0];
      status <= (status & ~clr) | ev;
      if (rd_en) rdata <= rd_mux;
    end
  end

  assign gpio_in_clean = clean;
  assign irq           = |status;

endmodule

// File: tb/tb_gpio_in_conditioner.sv
// Directed bench for gpio_in_conditioner (PRESCALE=4, STABLE_CNT=3); adapts to GPIO_IN_DEBOUNCE_EN.
module tb_gpio_in_conditioner;

`ifdef GPIO_IN_DEBOUNCE_EN
  localparam bit DB = 1'b1;
`else
  localparam bit DB = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] pad_in;
  logic        wr_en, rd_en;
  logic [7:0]  addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [31:0] gpio_in_clean;
  logic        irq;

  int checks = 0;
  int errors = 0;

  gpio_in_conditioner #(.WIDTH(32), .PRESCALE(4), .STABLE_CNT(3)) dut (
    .clk(clk), .rst(rst), .pad_in(pad_in), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .gpio_in_clean(gpio_in_clean), .irq(irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    wr_en = 1'b1; addr = a; wdata = d;
    @(negedge clk);
    wr_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, output logic [31:0] d);
    rd_en = 1'b1; addr = a;
    @(negedge clk);
    rd_en = 1'b0;
    d = rdata;
  endtask

  // Cycles from the current negedge until clean[0] reaches val; irq sampled just before and at that point.
  task automatic wait_clean0(input logic val, output int lat, output logic irq_before, output logic irq_at);
    lat = 0;
    irq_before = irq;
    while (gpio_in_clean[0] !== val && lat < 40) begin
      irq_before = irq;
      @(negedge clk);
      lat++;
    end
    irq_at = irq;
  endtask

  int          lat, lo, hi;
  logic        ib, ia, seen;
  logic [31:0] d;

  initial begin
    lo = DB ? 11 : 2;
    hi = DB ? 15 : 2;
    rst = 1'b1; pad_in = 32'hA5A5A5A5; wr_en = 1'b0; rd_en = 1'b0; addr = 8'h00; wdata = 32'h0;

    // Reset holds everything at zero even with pads active
    repeat (5) @(negedge clk);
    chk("rst_rdata", rdata, 32'h0);
    chk("rst_clean", gpio_in_clean, 32'h0);
    chk("rst_irq", 32'(irq), 32'd0);

    rst = 1'b0;
    lat = 0;
    while (gpio_in_clean !== 32'hA5A5A5A5 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("rst_clean_lat", 32'(lat >= lo && lat <= hi), 32'd1);
    rd(8'h10, d); chk("raw_read", d, 32'hA5A5A5A5);
    rd(8'h00, d); chk("clean_read", d, 32'hA5A5A5A5);
    chk("rst_irq_after", 32'(irq), 32'd0);

    // Drop all pads with no enables set
    pad_in = 32'h0;
    repeat (20) @(negedge clk);
    chk("idle_clean", gpio_in_clean, 32'h0);
    rd(8'h0C, d); chk("idle_status", d, 32'h0);

    // 6-cycle glitch on pin 0
    pad_in[0] = 1'b1;
    seen = 1'b0;
    for (int c = 0; c < 26; c++) begin
      if (c == 6) pad_in[0] = 1'b0;
      @(negedge clk);
      seen = seen | gpio_in_clean[0];
    end
    chk("glitch_seen", 32'(seen), DB ? 32'd0 : 32'd1);
    rd(8'h0C, d); chk("glitch_status", d, 32'h0);
    chk("glitch_irq", 32'(irq), 32'd0);

    // Enabled rise
    wr(8'h04, 32'h1);
    rd(8'h04, d); chk("rise_en_rd", d, 32'h1);
    pad_in[0] = 1'b1;
    wait_clean0(1'b1, lat, ib, ia);
    chk("rise_lat", 32'(lat >= lo && lat <= hi), 32'd1);
    chk("rise_irq_before", 32'(ib), 32'd0);
    chk("rise_irq_at", 32'(ia), 32'd1);
    rd(8'h0C, d); chk("rise_status", d, 32'h1);
    wr(8'h0C, 32'h1);
    chk("w1c_irq", 32'(irq), 32'd0);
    rd(8'h0C, d); chk("w1c_status", d, 32'h0);

    // Disabled fall, then enabling does not set STATUS retroactively
    pad_in[0] = 1'b0;
    repeat (20) @(negedge clk);
    chk("dfall_clean", gpio_in_clean, 32'h0);
    rd(8'h0C, d); chk("dfall_status", d, 32'h0);
    wr(8'h08, 32'h1);
    chk("fall_en_no_retro", 32'(irq), 32'd0);
    rd(8'h08, d); chk("fall_en_rd", d, 32'h1);

    // Clear held on every cycle while a rise qualifies: the set must win
    wr_en = 1'b1; addr = 8'h0C; wdata = 32'h1; pad_in[0] = 1'b1;
    lat = 0;
    while (gpio_in_clean[0] !== 1'b1 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("sbc_irq", 32'(irq), 32'd1);
    wr_en = 1'b0;
    rd(8'h0C, d); chk("sbc_status", d, 32'h1);

    // Enabled fall
    wr(8'h0C, 32'h1);
    chk("pre_fall_irq", 32'(irq), 32'd0);
    pad_in[0] = 1'b0;
    wait_clean0(1'b0, lat, ib, ia);
    chk("fall_lat", 32'(lat >= lo && lat <= hi), 32'd1);
    chk("fall_irq_at", 32'(ia), 32'd1);
    rd(8'h0C, d); chk("fall_status", d, 32'h1);

    // Bus corners
    rd(8'h14, d); chk("rd_0x14", d, 32'h0);
    wr(8'h00, 32'hFFFFFFFF);
    rd(8'h00, d); chk("clean_ro", d, 32'h0);
    wr(8'h10, 32'hFFFFFFFF);
    rd(8'h10, d); chk("raw_ro", d, 32'h0);
    wr_en = 1'b1; rd_en = 1'b1; addr = 8'h04; wdata = 32'h0;
    @(negedge clk);
    wr_en = 1'b0; rd_en = 1'b0;
    chk("rw_same_pre", rdata, 32'h1);
    rd(8'h04, d); chk("rw_same_post", d, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
